// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential 8x8 multiplier among NREQ requesters
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 12
) (
    input  logic              clk,
    input  logic              reset_a,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] a_in,
    input  logic [8*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [15:0]       rsp_product,
    output logic              rsp_err,
    output logic              busy,
    output logic              mult_start,
    output logic [7:0]        mult_dataa,
    output logic [7:0]        mult_datab,
    input  logic              mult_done,
    input  logic [15:0]       mult_product,
    output logic [1:0]        state_out
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        rr_q, rr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt;
    logic [7:0]        dataa_q, dataa_d, datab_q, datab_d, cnt_q, cnt_d, opa, opb;
    logic [15:0]       prod_q, prod_d;
    logic              err_q, err_d;
    logic [2*NREQ-1:0] dbl;
    logic [3:0]        idx;

    // First requester at or after rr (with wrap) and its operand pair
    always_comb begin
        dbl = {req, req} >> rr_q;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (dbl[k]) idx = {1'b0, rr_q} + 4'(k);
        gnt = (idx >= 4'(NREQ)) ? 3'(idx - 4'(NREQ)) : idx[2:0];
        opa = '0;
        opb = '0;
        for (int j = 0; j < NREQ; j++)
            if (gnt == 3'(j)) begin
                opa = a_in[8*j +: 8];
                opb = b_in[8*j +: 8];
            end
    end

    // Sequencer: grant in IDLE, pulse start, wait for done or watchdog, respond
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        dataa_d  = dataa_q;
        datab_d  = datab_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (|req) begin
                id_d    = gnt;
                dataa_d = opa;
                datab_d = opb;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (mult_done || cnt_q == 8'(TIMEOUT - 1)) begin
                prod_d   = mult_done ? mult_product : 16'd0;
                err_d    = !mult_done;
                rsp_id_d = id_q;
                state_d  = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: begin
                rr_d    = (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            id_q     <= '0;
            rsp_id_q <= '0;
            dataa_q  <= '0;
            datab_q  <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            dataa_q  <= dataa_d;
            datab_q  <= datab_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid   = state_q == RESP;
    assign ack         = rsp_valid ? NREQ'(1) << id_q : '0;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;
    assign busy        = state_q != IDLE;
    assign mult_start  = state_q == ISSUE;
    assign mult_dataa  = dataa_q;
    assign mult_datab  = datab_q;
    assign state_out   = state_q;
endmodule
